// File: rtl/rv_mem_pkg.sv
// Shared constants and types for the RV32 memory-access stage.
// Also carries the alignment-check helper used when MISALIGN_TRAP_EN is defined.
package rv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Stores are sized by mask, loads by func3; undefined func3 behaves as a word.
    function automatic logic is_misaligned(input logic [3:0] mask,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (mask != 4'b0000) begin
            case (mask)
                MASK_H:  bad = off[0];
                MASK_W:  bad = (off != 2'b00);
                default: bad = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = off[0];
                default:       bad = (off != 2'b00);
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_ls_align.sv
// Combinational lane alignment: store strobe/data shifting and load
// byte/half extraction with sign or zero extension.
module ls_align
    import rv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      st_off,
    input  logic [3:0]      st_mask,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      st_strb,
    output logic [XLEN-1:0] st_wdata,
    input  logic [1:0]      ld_off,
    input  logic [2:0]      ld_func3,
    input  logic [XLEN-1:0] ld_word,
    output logic [XLEN-1:0] ld_data
);

    logic [1:0]  st_lane_s;
    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store lane: offset bits finer than the access size are dropped.
    always_comb begin
        st_lane_s = 2'b00;
        case (st_mask)
            MASK_B:  st_lane_s = st_off;
            MASK_H:  st_lane_s = {st_off[1], 1'b0};
            default: st_lane_s = 2'b00;
        endcase
        st_strb  = st_mask << st_lane_s;
        st_wdata = st_data << {st_lane_s, 3'b000};
    end

    // Load extract and extend.
    always_comb begin
        ld_byte_s = 8'h00;
        ld_half_s = 16'h0000;
        ld_data   = ld_word;
        case (ld_off)
            2'b00:   ld_byte_s = ld_word[7:0];
            2'b01:   ld_byte_s = ld_word[15:8];
            2'b10:   ld_byte_s = ld_word[23:16];
            2'b11:   ld_byte_s = ld_word[31:24];
            default: ld_byte_s = ld_word[7:0];
        endcase
        ld_half_s = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_func3)
            F3_LB:   ld_data = {{(XLEN-8){ld_byte_s[7]}}, ld_byte_s};
            F3_LH:   ld_data = {{(XLEN-16){ld_half_s[15]}}, ld_half_s};
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte_s};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half_s};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 memory stage: E/M inputs -> req/ack data bus -> M/W register, with watchdog.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and pulse misalign_err.
module mem_access_stage
    import rv_mem_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m_valid,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_index,
    input  logic [3:0]      dm_w_en,
    input  logic            wb_sel,
    input  logic            wb_en,
    input  logic            halt,
    input  logic [2:0]      func3,
    input  logic            dm_ack,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic [3:0]      dm_wstrb,
    output logic            mem_stall,
    output logic            wb_valid_reg,
    output logic [XLEN-1:0] wb_data_reg,
    output logic [4:0]      rd_index_reg,
    output logic            wb_en_reg,
    output logic            halt_reg,
    output logic            bus_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misalign_err
`endif
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_e          state_r, state_s;
    logic [CW-1:0]   wait_cnt_r, cnt_s;
    logic [2:0]      func3_r;
    logic [1:0]      off_r;
    logic [XLEN-1:0] alu_r;
    logic [4:0]      rd_r;
    logic            wb_en_r, halt_r, is_load_r;
    logic            mem_op_s, misalign_s;
    logic            issue_s, finish_s, expire_s, trap_s;
    logic [3:0]      st_strb_s;
    logic [XLEN-1:0] st_wdata_s, ld_data_s;

    assign mem_op_s = m_valid & (wb_sel | (dm_w_en != 4'b0000));

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(dm_w_en, func3, alu_out[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    ls_align #(.XLEN(XLEN)) u_align (
        .st_off   (alu_out[1:0]),
        .st_mask  (dm_w_en),
        .st_data  (rs2_data),
        .st_strb  (st_strb_s),
        .st_wdata (st_wdata_s),
        .ld_off   (off_r),
        .ld_func3 (func3_r),
        .ld_word  (dm_rdata),
        .ld_data  (ld_data_s)
    );

    // Next-state, watchdog and stall decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = wait_cnt_r;
        issue_s   = 1'b0;
        finish_s  = 1'b0;
        expire_s  = 1'b0;
        trap_s    = 1'b0;
        mem_stall = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CW{1'b0}};
                if (mem_op_s && misalign_s) begin
                    trap_s = 1'b1;
                end else if (mem_op_s) begin
                    issue_s   = 1'b1;
                    mem_stall = 1'b1;
                    state_s   = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                mem_stall = ~dm_ack;
                if (dm_ack) begin
                    finish_s = 1'b1;
                    state_s  = ST_IDLE;
                    cnt_s    = {CW{1'b0}};
                end else if (wait_cnt_r == CW'(MAX_WAIT - 1)) begin
                    expire_s = 1'b1;
                    state_s  = ST_IDLE;
                    cnt_s    = {CW{1'b0}};
                end else begin
                    cnt_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, bus and M/W registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= {CW{1'b0}};
            func3_r      <= 3'b000;
            off_r        <= 2'b00;
            alu_r        <= {XLEN{1'b0}};
            rd_r         <= 5'd0;
            wb_en_r      <= 1'b0;
            halt_r       <= 1'b0;
            is_load_r    <= 1'b0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= {XLEN{1'b0}};
            dm_wdata     <= {XLEN{1'b0}};
            dm_wstrb     <= 4'b0000;
            wb_valid_reg <= 1'b0;
            wb_data_reg  <= {XLEN{1'b0}};
            rd_index_reg <= 5'd0;
            wb_en_reg    <= 1'b0;
            halt_reg     <= 1'b0;
            bus_err      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= cnt_s;
            bus_err    <= expire_s;
`ifdef MISALIGN_TRAP_EN
            misalign_err <= trap_s;
`endif
            if (issue_s) begin
                func3_r      <= func3;
                off_r        <= alu_out[1:0];
                alu_r        <= alu_out;
                rd_r         <= rd_index;
                wb_en_r      <= wb_en;
                halt_r       <= halt;
                is_load_r    <= wb_sel & (dm_w_en == 4'b0000);
                dm_req       <= 1'b1;
                dm_we        <= (dm_w_en != 4'b0000);
                dm_addr      <= {alu_out[XLEN-1:2], 2'b00};
                dm_wdata     <= st_wdata_s;
                dm_wstrb     <= st_strb_s;
                wb_valid_reg <= 1'b0;
                wb_en_reg    <= 1'b0;
                halt_reg     <= 1'b0;
            end else if (finish_s || expire_s) begin
                // A timed-out access retires with its write suppressed.
                dm_req       <= 1'b0;
                dm_we        <= 1'b0;
                wb_valid_reg <= 1'b1;
                wb_data_reg  <= (is_load_r && finish_s) ? ld_data_s : alu_r;
                rd_index_reg <= rd_r;
                wb_en_reg    <= wb_en_r & finish_s;
                halt_reg     <= halt_r;
            end else if (trap_s) begin
                wb_valid_reg <= 1'b1;
                wb_data_reg  <= alu_out;
                rd_index_reg <= rd_index;
                wb_en_reg    <= 1'b0;
                halt_reg     <= halt;
            end else if (state_r == ST_IDLE) begin
                wb_valid_reg <= m_valid;
                wb_data_reg  <= alu_out;
                rd_index_reg <= rd_index;
                wb_en_reg    <= m_valid & wb_en;
                halt_reg     <= m_valid & halt;
            end else begin
                wb_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (MAX_WAIT overridden to 4).
// Exercises the misalign trap only when MISALIGN_TRAP_EN is defined.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [4:0]  rd_index;
    logic [3:0]  dm_w_en;
    logic        wb_sel;
    logic        wb_en;
    logic        halt;
    logic [2:0]  func3;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        mem_stall;
    logic        wb_valid_reg;
    logic [31:0] wb_data_reg;
    logic [4:0]  rd_index_reg;
    logic        wb_en_reg;
    logic        halt_reg;
    logic        bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .alu_out      (alu_out),
        .rs2_data     (rs2_data),
        .rd_index     (rd_index),
        .dm_w_en      (dm_w_en),
        .wb_sel       (wb_sel),
        .wb_en        (wb_en),
        .halt         (halt),
        .func3        (func3),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_wstrb     (dm_wstrb),
        .mem_stall    (mem_stall),
        .wb_valid_reg (wb_valid_reg),
        .wb_data_reg  (wb_data_reg),
        .rd_index_reg (rd_index_reg),
        .wb_en_reg    (wb_en_reg),
        .halt_reg     (halt_reg),
        .bus_err      (bus_err)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    task automatic bubble();
        m_valid  = 1'b0;
        wb_sel   = 1'b0;
        wb_en    = 1'b0;
        dm_w_en  = 4'b0000;
        halt     = 1'b0;
        func3    = 3'b000;
        alu_out  = 32'h0;
        rs2_data = 32'h0;
        rd_index = 5'd0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        bubble();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, wb_valid_reg, wb_data_reg,
             rd_index_reg, wb_en_reg, halt_reg, bus_err} !== 105'd0)
            $display("FAIL reset_outputs: dm_req=%b wb_valid=%b wb_data=%h dm_addr=%h bus_err=%b, required all 0",
                     dm_req, wb_valid_reg, wb_data_reg, dm_addr, bus_err);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_non_mem();
        m_valid = 1'b1; alu_out = 32'h1234; rd_index = 5'd5; wb_en = 1'b1; halt = 1'b0;
        #1;
        n_checks++;
        if (mem_stall !== 1'b0) $display("FAIL nonmem_stall: got %b required 0", mem_stall);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({wb_valid_reg, wb_data_reg, rd_index_reg, wb_en_reg, dm_req, mem_stall} !== {1'b1, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b0})
            $display("FAIL nonmem_wb: valid=%b data=%h rd=%0d en=%b req=%b stall=%b, required 1 00001234 5 1 0 0",
                     wb_valid_reg, wb_data_reg, rd_index_reg, wb_en_reg, dm_req, mem_stall);
        else n_pass++;
        bubble();
        @(negedge clk);
        n_checks++;
        if ({wb_valid_reg, wb_en_reg, halt_reg} !== 3'b000)
            $display("FAIL bubble_wb: valid=%b en=%b halt=%b required 000", wb_valid_reg, wb_en_reg, halt_reg);
        else n_pass++;
    endtask

    task automatic test_sb_wait();
        int stall_cycles;
        stall_cycles = 0;
        m_valid = 1'b1; alu_out = 32'h103; rs2_data = 32'hAB; dm_w_en = 4'b0001; wb_sel = 1'b0;
        #1 stall_cycles += int'(mem_stall);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) begin dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF; end
            n_checks++;
            if ({dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, wb_valid_reg} !== {1'b1, 1'b1, 32'h100, 4'b1000, 32'hAB000000, 1'b0})
                $display("FAIL sb_bus_c%0d: req=%b we=%b addr=%h strb=%b wdata=%h wbv=%b, required 1 1 00000100 1000 ab000000 0",
                         c, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, wb_valid_reg);
            else n_pass++;
            #1 stall_cycles += int'(mem_stall);
        end
        @(negedge clk);
        dm_ack = 1'b0;
        n_checks++;
        if (stall_cycles !== 4) $display("FAIL sb_stall_cycles: got %0d required 4", stall_cycles);
        else n_pass++;
        n_checks++;
        if ({dm_req, wb_valid_reg, wb_data_reg, wb_en_reg} !== {1'b0, 1'b1, 32'h103, 1'b0})
            $display("FAIL sb_done: req=%b wbv=%b data=%h en=%b required 0 1 00000103 0",
                     dm_req, wb_valid_reg, wb_data_reg, wb_en_reg);
        else n_pass++;
        bubble();
        @(negedge clk);
    endtask

    task automatic test_loads();
        logic [31:0] va[8];
        logic [2:0]  vf[8];
        logic [31:0] vr[8];
        logic [31:0] ve[8];
        va[0] = 32'h102; vf[0] = 3'b000; vr[0] = 32'h00850000; ve[0] = 32'hFFFFFF85;
        va[1] = 32'h102; vf[1] = 3'b100; vr[1] = 32'h00850000; ve[1] = 32'h00000085;
        va[2] = 32'h002; vf[2] = 3'b001; vr[2] = 32'h80010000; ve[2] = 32'hFFFF8001;
        va[3] = 32'h002; vf[3] = 3'b101; vr[3] = 32'h80010000; ve[3] = 32'h00008001;
        va[4] = 32'h100; vf[4] = 3'b010; vr[4] = 32'h12345678; ve[4] = 32'h12345678;
        va[5] = 32'h101; vf[5] = 3'b100; vr[5] = 32'h00007F00; ve[5] = 32'h0000007F;
        va[6] = 32'h000; vf[6] = 3'b011; vr[6] = 32'hCAFEF00D; ve[6] = 32'hCAFEF00D;
        va[7] = 32'h203; vf[7] = 3'b000; vr[7] = 32'h80000000; ve[7] = 32'hFFFFFF80;
        for (int i = 0; i < 8; i++) begin
            m_valid = 1'b1; wb_sel = 1'b1; wb_en = 1'b1; rd_index = 5'd7;
            alu_out = va[i]; func3 = vf[i];
            #1;
            n_checks++;
            if (mem_stall !== 1'b1) $display("FAIL load%0d_issue_stall: got %b required 1", i, mem_stall);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({dm_req, dm_we, dm_addr} !== {1'b1, 1'b0, va[i] & 32'hFFFFFFFC})
                $display("FAIL load%0d_bus: req=%b we=%b addr=%h required 1 0 %h",
                         i, dm_req, dm_we, dm_addr, va[i] & 32'hFFFFFFFC);
            else n_pass++;
            dm_ack = 1'b1; dm_rdata = vr[i];
            #1;
            n_checks++;
            if (mem_stall !== 1'b0) $display("FAIL load%0d_ack_stall: got %b required 0", i, mem_stall);
            else n_pass++;
            @(negedge clk);
            dm_ack = 1'b0; dm_rdata = 32'h5A5A5A5A;
            bubble();
            n_checks++;
            if ({wb_valid_reg, wb_data_reg, wb_en_reg, rd_index_reg, dm_req} !== {1'b1, ve[i], 1'b1, 5'd7, 1'b0})
                $display("FAIL load%0d_wb: valid=%b data=%h en=%b rd=%0d req=%b required 1 %h 1 7 0",
                         i, wb_valid_reg, wb_data_reg, wb_en_reg, rd_index_reg, dm_req, ve[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_store_lanes();
        logic [31:0] sa[3], sd[3], sw[3];
        logic [3:0]  sm[3], ss[3];
        logic        sh[3];
        sa[0] = 32'h102; sd[0] = 32'h0000BEEF; sm[0] = 4'b0011; ss[0] = 4'b1100; sw[0] = 32'hBEEF0000; sh[0] = 1'b0;
        sa[1] = 32'h200; sd[1] = 32'h11223344; sm[1] = 4'b1111; ss[1] = 4'b1111; sw[1] = 32'h11223344; sh[1] = 1'b1;
        sa[2] = 32'h001; sd[2] = 32'h0000005A; sm[2] = 4'b0001; ss[2] = 4'b0010; sw[2] = 32'h00005A00; sh[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_valid = 1'b1; alu_out = sa[i]; rs2_data = sd[i]; dm_w_en = sm[i]; halt = sh[i]; rd_index = 5'd0;
            @(negedge clk);
            n_checks++;
            if ({dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, halt_reg} !== {1'b1, 1'b1, sa[i] & 32'hFFFFFFFC, ss[i], sw[i], 1'b0})
                $display("FAIL store%0d_bus: req=%b we=%b addr=%h strb=%b wdata=%h halt_reg=%b required 1 1 %h %b %h 0",
                         i, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, halt_reg, sa[i] & 32'hFFFFFFFC, ss[i], sw[i]);
            else n_pass++;
            dm_ack = 1'b1;
            @(negedge clk);
            dm_ack = 1'b0;
            bubble();
            n_checks++;
            if ({wb_valid_reg, wb_data_reg, wb_en_reg, halt_reg} !== {1'b1, sa[i], 1'b0, sh[i]})
                $display("FAIL store%0d_wb: valid=%b data=%h en=%b halt=%b required 1 %h 0 %b",
                         i, wb_valid_reg, wb_data_reg, wb_en_reg, halt_reg, sa[i], sh[i]);
            else n_pass++;
        end
    endtask

    task automatic test_idle_ack();
        bubble();
        dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dm_ack = 1'b0;
        n_checks++;
        if ({wb_valid_reg, dm_req, bus_err, mem_stall} !== 4'b0000)
            $display("FAIL idle_ack: valid=%b req=%b err=%b stall=%b required 0000", wb_valid_reg, dm_req, bus_err, mem_stall);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        m_valid = 1'b1; wb_sel = 1'b1; wb_en = 1'b1; func3 = 3'b010; alu_out = 32'h40; rd_index = 5'd9;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({dm_req, bus_err, mem_stall} !== 3'b101)
                $display("FAIL wd_busy_c%0d: req=%b err=%b stall=%b required 101", c, dm_req, bus_err, mem_stall);
            else n_pass++;
        end
        @(negedge clk);
        bubble();
        n_checks++;
        if ({bus_err, dm_req, wb_valid_reg, wb_en_reg, rd_index_reg} !== {1'b1, 1'b0, 1'b1, 1'b0, 5'd9})
            $display("FAIL wd_expire: err=%b req=%b valid=%b en=%b rd=%0d required 1 0 1 0 9",
                     bus_err, dm_req, wb_valid_reg, wb_en_reg, rd_index_reg);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus_err, wb_valid_reg, dm_req} !== 3'b000)
            $display("FAIL wd_pulse_end: err=%b valid=%b req=%b required 000", bus_err, wb_valid_reg, dm_req);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        m_valid = 1'b1; wb_sel = 1'b1; wb_en = 1'b1; func3 = 3'b010; alu_out = 32'h80; rd_index = 5'd3;
        @(negedge clk);
        n_checks++;
        if (dm_req !== 1'b1) $display("FAIL rstmid_busy: req=%b required 1", dm_req);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bubble();
        n_checks++;
        if ({dm_req, dm_we, dm_addr, wb_valid_reg, wb_data_reg, wb_en_reg, halt_reg, bus_err} !== 70'd0)
            $display("FAIL rstmid_clear: req=%b addr=%h valid=%b data=%h required all 0",
                     dm_req, dm_addr, wb_valid_reg, wb_data_reg);
        else n_pass++;
        dm_ack = 1'b1; dm_rdata = 32'h77777777;
        @(negedge clk);
        dm_ack = 1'b0;
        n_checks++;
        if ({wb_valid_reg, dm_req, wb_en_reg} !== 3'b000)
            $display("FAIL rstmid_late_ack: valid=%b req=%b en=%b required 000", wb_valid_reg, dm_req, wb_en_reg);
        else n_pass++;
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        m_valid = 1'b1; wb_sel = 1'b1; wb_en = 1'b1; func3 = 3'b010; alu_out = 32'h101; rd_index = 5'd4;
        #1;
        n_checks++;
        if (mem_stall !== 1'b0) $display("FAIL mis_stall: got %b required 0", mem_stall);
        else n_pass++;
        @(negedge clk);
        bubble();
        n_checks++;
        if ({dm_req, misalign_err, wb_valid_reg, wb_en_reg} !== 4'b0110)
            $display("FAIL mis_trap: req=%b merr=%b valid=%b en=%b required 0110", dm_req, misalign_err, wb_valid_reg, wb_en_reg);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (misalign_err !== 1'b0) $display("FAIL mis_pulse_end: got %b required 0", misalign_err);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_non_mem();
        test_sb_wait();
        test_loads();
        test_store_lanes();
        test_idle_ack();
        test_watchdog();
        test_reset_mid();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
